// File: rtl/button_reader.sv
// button_reader -- debounced push-button input reader.
//
// Takes one raw, asynchronous button pin and produces a clean pressed level
// plus single-cycle press, release and long-press events. Everything runs in
// the single board clock domain.
//
// Ports:
//   clk            board clock, all logic on the rising edge
//   reset          synchronous, active-high reset
//   btn_in         raw asynchronous button pin
//   btn_level      debounced level, 1 = pressed
//   press_pulse    one-cycle pulse on an accepted press
//   release_pulse  one-cycle pulse on an accepted release
//   long_pulse     one-cycle pulse once per press after LONG_CYCLES held cycles
//   press_count    accepted presses, modulo 256
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a press or release (>= 2)
//   LONG_CYCLES      held cycles before the long-press event (> DEBOUNCE_CYCLES)
//   ACTIVE_LOW       1: pin reads 0 when pressed, 0: pin reads 1 when pressed
module button_reader #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 12000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  localparam int QW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);

  localparam logic [QW-1:0] Q_LAST = QW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] H_PRE  = HW'(LONG_CYCLES - 2);

  // Pin level that means "not pressed"; the synchroniser resets to it so a
  // reset never looks like a press edge.
  localparam logic IDLE_LVL = ACTIVE_LOW;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_QUAL   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_QUAL = 2'd3
  } state_t;

  state_t          state;
  logic            sync_p0;
  logic            sync_p1;
  logic [QW-1:0]   q;
  logic [HW-1:0]   h;
  logic            p;

  // Hold counter saturates at its last value so the long-press edge can only
  // ever be crossed once per press.
  function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
    return (v == H_LAST) ? v : v + HW'(1);
  endfunction

  // Synchronised pin, normalised so 1 = pressed.
  assign p = sync_p1 ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0       <= IDLE_LVL;
      sync_p1       <= IDLE_LVL;
      state         <= RELEASED;
      q             <= '0;
      h             <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      // Stage p0 -> p1: two-flop synchroniser on the raw pin.
      sync_p0 <= btn_in;
      sync_p1 <= sync_p0;

      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;

      case (state)
        RELEASED: begin
          if (p) begin
            state <= PRESS_QUAL;
            q     <= '0;
          end
        end

        PRESS_QUAL: begin
          if (!p) begin
            state <= RELEASED;
          end else if (q == Q_LAST) begin
            state       <= PRESSED;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
            press_count <= press_count + 8'd1;
            h           <= '0;
          end else begin
            q <= q + QW'(1);
          end
        end

        PRESSED: begin
          // h only advances on cycles where the button is still seen held;
          // the cycle that starts a release qualification leaves it frozen.
          if (!p) begin
            state <= RELEASE_QUAL;
            q     <= '0;
          end else begin
            h <= sat_inc(h);
            if (h == H_PRE) begin
              long_pulse <= 1'b1;
            end
          end
        end

        RELEASE_QUAL: begin
          if (p) begin
            state <= PRESSED;
          end else if (q == Q_LAST) begin
            state         <= RELEASED;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            q <= q + QW'(1);
          end
        end

        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_button_reader.sv
// Testbench for button_reader with DEBOUNCE_CYCLES=4, LONG_CYCLES=16,
// ACTIVE_LOW=1. A behavioural reference model tracks run lengths of the
// delayed pin against the accepted level and is compared every cycle;
// directed steps add fixed-latency and event-count checks.
module tb_button_reader;

  localparam int D  = 4;
  localparam int L  = 16;
  localparam bit AL = 1'b1;

  logic       clk;
  logic       reset;
  logic       btn_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  int checks = 0;
  int errors = 0;
  int n_press = 0;
  int n_rel = 0;
  int n_long = 0;

  // Reference model state
  bit d1, d2;          // pressed-normalised pin, one and two edges back
  bit m_level;
  int m_run;           // consecutive edges where the delayed pin disagrees with the level
  int m_hold;          // held edges since the accepted press
  int m_count;
  bit m_press, m_rel, m_long;

  button_reader #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L),
    .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the level flips once the twice-delayed pin has disagreed with it
  // on D+1 consecutive edges. Held time counts only edges where the pin
  // agrees with a pressed level and no release disagreement is pending.
  always @(posedge clk) begin
    bit pv;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
    if (reset) begin
      d1 = 1'b0; d2 = 1'b0;
      m_level = 1'b0; m_run = 0; m_hold = 0; m_count = 0;
    end else begin
      pv = d2;
      d2 = d1;
      d1 = btn_in ^ AL;
      if (pv != m_level) begin
        m_run++;
        if (m_run == D + 1) begin
          m_level = pv;
          m_run = 0;
          if (pv) begin
            m_press = 1'b1;
            m_count = (m_count + 1) % 256;
            m_hold = 0;
          end else begin
            m_rel = 1'b1;
          end
        end
      end else begin
        if (m_level && m_run == 0 && m_hold < L - 1) begin
          m_hold++;
          if (m_hold == L - 1) m_long = 1'b1;
        end
        m_run = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic pin);
    btn_in = pin;
    @(posedge clk);
    @(negedge clk);
    chk("model_level", 32'(btn_level), 32'(m_level));
    chk("model_press", 32'(press_pulse), 32'(m_press));
    chk("model_release", 32'(release_pulse), 32'(m_rel));
    chk("model_long", 32'(long_pulse), 32'(m_long));
    chk("model_count", 32'(press_count), 32'(m_count));
    chk("pulse_overlap", 32'(int'(press_pulse) + int'(release_pulse) + int'(long_pulse) > 1), 32'd0);
    n_press += int'(press_pulse);
    n_rel   += int'(release_pulse);
    n_long  += int'(long_pulse);
  endtask

  initial begin
    int s_press, s_rel, s_long, len;
    logic pin;

    reset  = 1'b1;
    btn_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_level", 32'(btn_level), 32'd0);
    chk("reset_press", 32'(press_pulse), 32'd0);
    chk("reset_release", 32'(release_pulse), 32'd0);
    chk("reset_long", 32'(long_pulse), 32'd0);
    chk("reset_count", 32'(press_count), 32'd0);
    reset = 1'b0;
    repeat (3) tick(1'b1);

    // Clean press, long press, release
    repeat (6) tick(1'b0);
    chk("press_early", 32'(press_pulse), 32'd0);
    tick(1'b0);
    chk("press_pulse", 32'(press_pulse), 32'd1);
    chk("press_level", 32'(btn_level), 32'd1);
    chk("press_count1", 32'(press_count), 32'd1);
    tick(1'b0);
    chk("press_one_cycle", 32'(press_pulse), 32'd0);
    repeat (13) tick(1'b0);
    chk("long_early", 32'(long_pulse), 32'd0);
    tick(1'b0);
    chk("long_pulse", 32'(long_pulse), 32'd1);
    tick(1'b0);
    chk("long_one_cycle", 32'(long_pulse), 32'd0);
    repeat (6) tick(1'b1);
    chk("release_early", 32'(release_pulse), 32'd0);
    tick(1'b1);
    chk("release_pulse", 32'(release_pulse), 32'd1);
    chk("release_level", 32'(btn_level), 32'd0);
    repeat (3) tick(1'b1);

    // Glitch rejection: 3 cycles low
    s_press = n_press;
    repeat (3) tick(1'b0);
    repeat (10) tick(1'b1);
    chk("glitch_no_press", 32'(n_press - s_press), 32'd0);
    chk("glitch_level", 32'(btn_level), 32'd0);
    chk("glitch_count", 32'(press_count), 32'd1);

    // Release bounce while pressed
    repeat (7) tick(1'b0);
    s_rel = n_rel; s_long = n_long;
    repeat (3) tick(1'b0);
    repeat (2) tick(1'b1);
    repeat (30) tick(1'b0);
    chk("bounce_no_release", 32'(n_rel - s_rel), 32'd0);
    chk("bounce_level", 32'(btn_level), 32'd1);
    chk("bounce_long_once", 32'(n_long - s_long), 32'd1);
    repeat (9) tick(1'b1);

    // Short press below L
    repeat (7) tick(1'b0);
    s_long = n_long;
    repeat (10) tick(1'b0);
    repeat (6) tick(1'b1);
    chk("short_release_early", 32'(release_pulse), 32'd0);
    tick(1'b1);
    chk("short_release", 32'(release_pulse), 32'd1);
    chk("short_no_long", 32'(n_long - s_long), 32'd0);
    repeat (3) tick(1'b1);

    // Reset mid-hold
    repeat (12) tick(1'b0);
    s_rel = n_rel;
    reset = 1'b1;
    tick(1'b0);
    reset = 1'b0;
    chk("rst_level", 32'(btn_level), 32'd0);
    chk("rst_count", 32'(press_count), 32'd0);
    chk("rst_press", 32'(press_pulse), 32'd0);
    chk("rst_release", 32'(release_pulse), 32'd0);
    chk("rst_long", 32'(long_pulse), 32'd0);
    repeat (6) tick(1'b0);
    chk("rst_press_early", 32'(press_pulse), 32'd0);
    chk("rst_no_release", 32'(n_rel - s_rel), 32'd0);
    tick(1'b0);
    chk("rst_repress", 32'(press_pulse), 32'd1);
    repeat (9) tick(1'b1);

    // Counter wrap: 257 presses from zero
    reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
    s_press = n_press; s_long = n_long;
    for (int i = 0; i < 257; i++) begin
      repeat (9) tick(1'b0);
      repeat (9) tick(1'b1);
    end
    chk("wrap_count", 32'(press_count), 32'd1);
    chk("wrap_presses", 32'(n_press - s_press), 32'd257);
    chk("wrap_no_long", 32'(n_long - s_long), 32'd0);

    // Randomised runs with occasional resets
    pin = 1'b1;
    for (int i = 0; i < 400; i++) begin
      len = $urandom_range(1, 24);
      pin = ~pin;
      repeat (len) tick(pin);
      if ($urandom_range(0, 30) == 0) begin
        reset = 1'b1;
        tick(pin);
        reset = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
